// File: rtl/ring_arb_pkg.sv
// Shared types and helpers for the rotating-priority ring arbiter.
// Helpers work on a fixed maximum width; callers size-cast to their own N.
package ring_arb_pkg;

  localparam int unsigned MaxN = 32;
  localparam int unsigned MaxW = $clog2(MaxN);

  typedef enum logic [0:0] {StIdle, StBusy} arb_state_e;

  // Rotate a one-hot vector of width n one place toward bit 0, wrapping bit 0 to bit n-1.
  function automatic logic [MaxN-1:0] rotate_right(input logic [MaxN-1:0] onehot,
                                                   input int unsigned n);
    logic [MaxN-1:0] r;
    r = onehot >> 1;
    if (onehot[0]) r[MaxW'(n - 1)] = 1'b1;
    return r;
  endfunction

  function automatic int unsigned onehot2idx(input logic [MaxN-1:0] onehot);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (onehot[MaxW'(i)]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_ptr.sv
// One-hot rotating priority pointer: resets to the MSB, loads the bit just below the
// last winner, and freezes while disabled.
module ring_ptr
  import ring_arb_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk_i,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [N-1:0] win_i,
  output logic [N-1:0] ptr_o
);

  localparam logic [N-1:0] PtrRst = {1'b1, {(N-1){1'b0}}};

  logic [N-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (load_i) ptr_d = N'(rotate_right(MaxN'(win_i), N));
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      ptr_q <= PtrRst;
    end else if (en_i) begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a rotating one-hot priority ring and a bounded grant tenure.
// All outputs come straight from registers.
module ring_rr_arbiter
  import ring_arb_pkg::*;
#(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 8,
  parameter int unsigned IW       = $clog2(N)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  grant,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  localparam int unsigned HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);

  arb_state_e    state_d, state_q;
  logic [N-1:0]  grant_d, grant_q;
  logic [IW-1:0] idx_d, idx_q;
  logic [HW-1:0] hold_d, hold_q;
  logic [N-1:0]  ptr;
  logic [N-1:0]  win_oh;
  logic [IW-1:0] win_idx;
  logic          win_valid;
  logic          load;
  logic          keep;

  ring_ptr #(
    .N (N)
  ) u_ptr (
    .clk_i  (clk),
    .clr_i  (clr),
    .en_i   (en),
    .load_i (load),
    .win_i  (win_oh),
    .ptr_o  (ptr)
  );

  // Wrap-scan from the pointer bit downward; the first set request wins.
  always_comb begin
    int unsigned ptr_idx;
    int unsigned j;
    win_oh    = '0;
    win_idx   = '0;
    win_valid = 1'b0;
    ptr_idx   = onehot2idx(MaxN'(ptr));
    for (int unsigned off = 0; off < N; off++) begin
      j = (ptr_idx + N - off) % N;
      if (!win_valid && req[IW'(j)]) begin
        win_valid        = 1'b1;
        win_oh[IW'(j)]   = 1'b1;
        win_idx          = IW'(j);
      end
    end
  end

  assign keep = (|(req & grant_q)) && (hold_q < HoldLast);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_valid) begin
          state_d = StBusy;
          grant_d = win_oh;
          idx_d   = win_idx;
          hold_d  = '0;
          load    = 1'b1;
        end
      end
      StBusy: begin
        if (keep) begin
          hold_d = hold_q + 1'b1;
        end else if (win_valid) begin
          // Handoff without a bubble; may re-grant the same owner if it is alone.
          grant_d = win_oh;
          idx_d   = win_idx;
          hold_d  = '0;
          load    = 1'b1;
        end else begin
          state_d = StIdle;
          grant_d = '0;
          idx_d   = '0;
          hold_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        idx_d   = '0;
        hold_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= StIdle;
      grant_q <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
    end else if (en) begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_idx   = idx_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Directed bench for ring_rr_arbiter (N=4, MAX_HOLD=4) with an expected-grant scoreboard.
module tb_ring_rr_arbiter;

  localparam int unsigned N        = 4;
  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned IW       = 2;

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_idx;

  typedef struct {
    logic [N-1:0] grant;
    int           hold;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  always #5 clk = ~clk;

  ring_rr_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD),
    .IW       (IW)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .en          (en),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  function automatic logic [IW-1:0] idx_of(input logic [N-1:0] g);
    logic [IW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) if (g[i]) r = IW'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Drive one cycle of inputs, queue the expected result, and compare after the edge.
  // A negative hold skips the tenure-counter comparison.
  task automatic step(input logic c, input logic e, input logic [N-1:0] r,
                      input logic [N-1:0] g, input int h);
    exp_t x;
    clr = c;
    en  = e;
    req = r;
    x.grant = g;
    x.hold  = h;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check("grant", 32'(grant), 32'(x.grant));
    check("grant_valid", 32'(grant_valid), 32'(|x.grant));
    check("grant_idx", 32'(grant_idx), 32'(idx_of(x.grant)));
    if (x.hold >= 0) check("hold_cnt", 32'(dut.hold_q), 32'(x.hold));
  endtask

  initial begin
    logic [N-1:0] g;

    // Reset with all requests up
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 0);
    step(1'b1, 1'b1, 4'b1111, 4'b0000, 0);
    check("ptr_reset", 32'(dut.u_ptr.ptr_q), 32'(4'b1000));

    // Saturation rotation: 1000x4, 0100x4, 0010x4, 0001x4, then wrap
    for (int i = 0; i < 17; i++) begin
      g = 4'b1000 >> ((i / 4) % 4);
      step(1'b0, 1'b1, 4'b1111, g, i % 4);
    end
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 0);

    // Single request then release
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 0);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 0);

    // Early release handoff, from a fresh pointer
    step(1'b1, 1'b1, 4'b0000, 4'b0000, 0);
    step(1'b0, 1'b1, 4'b0101, 4'b0100, 0);
    step(1'b0, 1'b1, 4'b0001, 4'b0001, 0);
    step(1'b0, 1'b1, 4'b1001, 4'b0001, 1);
    step(1'b0, 1'b1, 4'b1000, 4'b1000, 0);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 0);

    // Lone requester: continuous grant, tenure counter wraps three times
    for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 4'b0010, 4'b0010, i % 4);
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 0);

    // Freeze at hold_cnt=2 with req wiggling, then resume and abort
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 0);
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 1);
    step(1'b0, 1'b1, 4'b0010, 4'b0010, 2);
    step(1'b0, 1'b0, 4'b1111, 4'b0010, 2);
    step(1'b0, 1'b0, 4'b0000, 4'b0010, 2);
    step(1'b0, 1'b0, 4'b0101, 4'b0010, 2);
    step(1'b0, 1'b0, 4'b1000, 4'b0010, 2);
    step(1'b0, 1'b0, 4'b0001, 4'b0010, 2);
    step(1'b0, 1'b1, 4'b0110, 4'b0010, 3);
    step(1'b1, 1'b1, 4'b0110, 4'b0000, 0);
    check("ptr_abort", 32'(dut.u_ptr.ptr_q), 32'(4'b1000));
    step(1'b0, 1'b1, 4'b0000, 4'b0000, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ring_rr_arbiter.md
# ring_rr_arbiter

Round-robin arbiter that shares one resource among N requesters using a rotating one-hot priority ring. Priority moves MSB→LSB and wraps LSB→MSB, the same rotation order as the team's ring counters. A grant is held while its request stays high, up to a maximum tenure, then the arbiter forces rotation. It sits in front of any shared datapath element (bus, memory port, counter bank) and drives that element's select lines.

## Interface
- N, default 4: number of requesters, ≥2.
- MAX_HOLD, default 8: maximum consecutive cycles one grant may be held, ≥1.
- IW, default $clog2(N): width of grant_idx.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- clr  input  1  synchronous active-high reset. Overrides en and all other inputs.
- en  input  1  enable. When low, all state and outputs freeze.
- req  input  N  request vector, one bit per requester, level-sensitive.
- grant  output  N  registered one-hot grant, or all-zero.
- grant_valid  output  1  registered; equals |grant.
- grant_idx  output  IW  registered binary index of the granted bit; 0 when grant_valid is 0.

## Operation
- State: FSM {IDLE, BUSY}, one-hot priority pointer ptr[N-1:0], hold counter hold_cnt (width $clog2(MAX_HOLD+1)), current owner k.
- Reset (clr=1 at edge): state=IDLE, ptr=1 at bit N-1 (for N=4: 1000), hold_cnt=0, grant=0, grant_valid=0, grant_idx=0.
- Arbitration function: scan from the ptr bit downward toward bit 0, wrap to bit N-1, and stop at the first set req bit. That bit is the winner. If req=0, there is no winner.
- IDLE: if there is a winner w, go to BUSY, grant=onehot(w), hold_cnt=0, ptr=onehot(w-1 mod N). If there is no winner, stay in IDLE.
- BUSY, owner k:
  - If req[k]=1 and hold_cnt<MAX_HOLD-1: keep the grant and increment hold_cnt.
  - Otherwise (release or tenure expired), re-arbitrate with the current ptr:
    - If there is a winner w, grant it on the next edge with no idle bubble, set hold_cnt=0 and ptr=onehot(w-1 mod N). w may equal k if k is the only requester; the grant then stays continuous and hold_cnt restarts.
    - If there is no winner, go to IDLE with grant=0.
- After a grant, the granted requester always has the lowest priority.
- en=0: no state changes, outputs hold their values, and req is ignored.
- clr asserted mid-grant: grant drops to 0 on that edge and ptr returns to MSB. Any tenure in progress is discarded.
- Non-owner req changes during BUSY have no effect until re-arbitration.

## Timing
- Request to grant latency: 1 cycle. req is sampled at edge t and grant is visible after edge t.
- Release latency: 1 cycle. If req[k] is low at edge t, grant[k] drops or moves after edge t.
- One owner's maximum continuous tenure is exactly MAX_HOLD enabled cycles when other requesters are waiting.
- grant, grant_valid and grant_idx change only on a clk edge and are mutually consistent every cycle.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package ring_arb_pkg holds:
  - the state typedef {IDLE, BUSY};
  - function rotate_right(onehot), which wraps LSB→MSB;
  - function onehot2idx.
- Sub-module ring_ptr holds the priority pointer: a parameterized one-hot rotating register with a load port. It resets to MSB-set, loads onehot(w-1), and freezes on !en.
- The top level holds the FSM, the hold counter and the wrap-scan priority search (double-width req masking or a loop).

## Test plan
Use N=4, MAX_HOLD=4 unless noted.
1. Reset: clr=1 for 2 cycles with req=1111 → grant=0000, grant_valid=0, grant_idx=0. On the first edge after clr drops, grant=1000.
2. Single request: req=0010 from IDLE → grant=0010 and grant_idx=1 one cycle later. When req drops to 0000 → grant=0000 one cycle later, state IDLE.
3. Saturation rotation: req=1111 held constant → grant sequence 1000×4, 0100×4, 0010×4, 0001×4, then 1000 again (wrap), with no bubbles.
4. Early release handoff: grant=0100 with req=0101. Drop bit 2 → the next cycle shows grant=0001 directly. Then raise req=1001 → 1000 is served after 0001 releases.
5. Lone requester timeout: req=0010 held for 12 cycles → grant stays 0010 continuously, grant_valid never drops, and hold_cnt cycles 0..3 three times.
6. Freeze and abort: during a grant at hold_cnt=2, en=0 for 5 cycles with req changing → outputs and hold_cnt unchanged. Restoring en resumes the tenure at hold_cnt=2. Asserting clr mid-grant → grant=0000 next cycle and ptr=1000.
